demux_1x4_tdm: RTL
==================

# demux_1x4_tdm

Time-division 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 line mux when that mux is driven by a rotating select to interleave four channels onto one link. Accepts one word per valid cycle, locks to a frame marker on slot 0, and steers successive words to four registered output lanes. It also reports frame completion and synchronisation errors.

## Interface

- `WIDTH`, 8, bits per slot word (1..32)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `d_in`  in  WIDTH  interleaved word
- `in_valid`  in  1  `d_in` holds a word this cycle
- `frame_sync`  in  1  qualified by `in_valid`; marks the slot-0 word of a frame
- `err_clr`  in  1  clears `sync_err`
- `out_0`, `out_1`, `out_2`, `out_3`  out  WIDTH each  lane registers
- `out_valid`  out  4  bit k pulses one cycle when `out_k` is updated
- `frame_done`  out  1  one-cycle pulse when the slot-3 word of a locked frame is captured
- `locked`  out  1  high in the LOCKED state
- `sync_err`  out  1  sticky error flag

## Operation

- **Reset values:** all `out_k` = 0, `out_valid` = 0, `frame_done` = 0, `locked` = 0, `sync_err` = 0, state = HUNT, `slot` = 0.
- **`slot` counter:** 2 bits. It advances only on accepted words and wraps 3 -> 0.
- **HUNT state:**
  - `in_valid` with `frame_sync` = 0: the word is dropped.
  - `in_valid` with `frame_sync` = 1: the word goes to lane 0, `slot` becomes 1, state goes to LOCKED.
- **LOCKED state,** on `in_valid`:
  - `slot` != 0, `frame_sync` = 0: the word goes to lane `slot`, `slot` increments. At `slot` = 3 this also pulses `frame_done` and wraps `slot` to 0.
  - `slot` = 0, `frame_sync` = 1: the word goes to lane 0, `slot` becomes 1. This is a normal frame start.
  - `slot` != 0, `frame_sync` = 1 (early sync): set `sync_err`, put the word in lane 0, set `slot` to 1, and stay LOCKED. The partial frame is abandoned and no `frame_done` pulses.
  - `slot` = 0, `frame_sync` = 0 (missing sync): set `sync_err`, drop the word, set state to HUNT.
- **Idle cycles:** no state change and all outputs hold, apart from the one-cycle pulses.
- **`sync_err`:** set by either error above and cleared by `err_clr`. If an error and `err_clr` occur in the same cycle, set wins.
- **`rst` mid-frame:** `rst` overrides every other input in the same cycle. The partial frame is discarded and the block returns to HUNT.

## Timing

- **Latency:** a word accepted at edge N appears on `out_k`, with `out_valid[k]` = 1, after edge N, i.e. in cycle N+1.
- **`frame_done`:** asserted in the same cycle as `out_valid[3]` for a completed frame.
- **Throughput:** one word per cycle. Frames may be back-to-back, so the slot-0 word can directly follow the slot-3 word.
- **No backpressure:** the block is always ready and has no ready output.
- **Registered outputs:** every output is a flop; no combinational path runs from inputs to outputs.
- **`locked`:** reflects the state after the edge.

## Configuration

- **`DEMUX_FRAME_BUF_EN` undefined:** each lane register updates at its own capture, as described above.
- **`DEMUX_FRAME_BUF_EN` defined:** words for slots 0..3 land in shadow registers.
  - All four `out_k` load together on the completing slot-3 capture.
  - `out_valid` = 4'b1111 for that one cycle, coincident with `frame_done`.
  - An abandoned partial frame (early sync, missing sync, `rst`) never reaches `out_k`. `out_k` keeps the last complete frame; `rst` still clears it to 0.
- Latency from the slot-3 word to the outputs stays 1 cycle.

## Structure

- **Package `mux_demux_pkg`:**
  - state encoding `HUNT` = 1'b0, `LOCKED` = 1'b1
  - `SLOT_W` = 2, `N_LANES` = 4
  - lane-index constants shared with the transmit-side mux sequencer
- **Sub-module `demux_lane_reg`:**
  - WIDTH-bit register with load enable and synchronous clear
  - registered valid pulse
  - instantiated four times, with a second set of four as shadows under `DEMUX_FRAME_BUF_EN`
- **Top level:** holds the FSM, the slot counter, the error logic and the lane-enable decode (2-to-4 decoder on `slot`).

## Test plan

- **Clean frames:** reset, then send words A0,A1,A2,A3 with sync on A0, back-to-back with a second frame B0..B3 -> `out_0`..`out_3` = 8'hA0..8'hA3, then 8'hB0..8'hB3. Expect `frame_done` twice, `sync_err` = 0, `locked` = 1 from the first word onward.
- **Hunt:** send 8'h11, 8'h22 without sync, then 8'h33 with sync -> first two dropped (`out_valid` stays 0), `out_0` = 8'h33, `locked` = 1.
- **Early sync:** lock, send two words, then sync on 8'h5A -> `sync_err` = 1, `out_0` = 8'h5A, no `frame_done`. The next three words fill lanes 1..3 and `frame_done` pulses.
- **Missing sync and clear:** after a full frame send 8'h77 without sync -> word dropped, `locked` = 0, `sync_err` = 1. Assert `err_clr` alone -> `sync_err` = 0. Assert `err_clr` together with a new error -> `sync_err` stays 1.
- **Reset mid-frame with gaps:** insert idle cycles between words, then assert `rst` after slot 2 -> all outputs 0 and HUNT next cycle. With `DEMUX_FRAME_BUF_EN` defined, also check that `out_k` is unchanged until the slot-3 capture and that `out_valid` = 4'b1111.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// ---------------------------------------------------------------------------
// mux_demux_pkg
// Shared definitions for the TDM line mux / demux pair.
//   - state_e   : receive framer state (HUNT searching for slot 0, LOCKED)
//   - SLOT_W    : width of the slot counter
//   - N_LANES   : number of interleaved channels
//   - LANE_0..3 : slot/lane indices, common to the transmit-side sequencer
//   - slot_to_lane_en : 2-to-4 one-hot decode of a slot index
// ---------------------------------------------------------------------------
package mux_demux_pkg;

    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned N_LANES = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [SLOT_W-1:0] LANE_0 = 2'd0;
    localparam logic [SLOT_W-1:0] LANE_1 = 2'd1;
    localparam logic [SLOT_W-1:0] LANE_2 = 2'd2;
    localparam logic [SLOT_W-1:0] LANE_3 = 2'd3;

    function automatic logic [N_LANES-1:0] slot_to_lane_en(input logic [SLOT_W-1:0] slot);
        logic [N_LANES-1:0] one_hot;
        one_hot       = '0;
        one_hot[slot] = 1'b1;
        return one_hot;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// ---------------------------------------------------------------------------
// demux_lane_reg
// One lane holding register: WIDTH-bit data flop with load enable and a
// synchronous clear, plus a one-cycle valid pulse marking each load.
// Ports:
//   clk   in   clock (rising edge)
//   rst   in   synchronous clear, active-high (data and valid to 0)
//   load  in   capture d this cycle
//   d     in   WIDTH data to capture
//   q     out  WIDTH registered data
//   valid out  high for the one cycle after a load
// ---------------------------------------------------------------------------
module demux_lane_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= load;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/demux_1x4_tdm.sv
// ---------------------------------------------------------------------------
// demux_1x4_tdm
// Time-division 1-to-4 demultiplexer. Locks onto a frame marker on slot 0
// and steers successive accepted words to four registered output lanes.
// Reports frame completion and a sticky synchronisation error.
//
// Build option: DEMUX_FRAME_BUF_EN
//   undefined : each lane updates at its own capture.
//   defined   : words collect in shadow registers and all four lanes load
//               together on the completing slot-3 capture; partial frames
//               never reach the outputs.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   d_in       in   WIDTH interleaved word
//   in_valid   in   d_in holds a word this cycle
//   frame_sync in   marks the slot-0 word (qualified by in_valid)
//   err_clr    in   clears sync_err (a simultaneous new error wins)
//   out_0..3   out  WIDTH lane registers
//   out_valid  out  4, bit k pulses when out_k is updated
//   frame_done out  pulse when a locked frame's slot-3 word is captured
//   locked     out  framer is in LOCKED
//   sync_err   out  sticky error flag
// ---------------------------------------------------------------------------
module demux_1x4_tdm
    import mux_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   d_in,
    input  logic               in_valid,
    input  logic               frame_sync,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   out_0,
    output logic [WIDTH-1:0]   out_1,
    output logic [WIDTH-1:0]   out_2,
    output logic [WIDTH-1:0]   out_3,
    output logic [N_LANES-1:0] out_valid,
    output logic               frame_done,
    output logic               locked,
    output logic               sync_err
);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                sync_err_q, sync_err_d;
    logic                frame_done_q, frame_done_d;

    logic [N_LANES-1:0]  lane_en;     // word captured into this slot now
    logic                err_set;

    logic [WIDTH-1:0]    lane_q    [N_LANES];
    logic [WIDTH-1:0]    lane_din  [N_LANES];
    logic [N_LANES-1:0]  lane_load;
    logic [N_LANES-1:0]  lane_valid;

    // -----------------------------------------------------------------------
    // Framer: next state, slot counter, capture decode, error detection
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        lane_en      = '0;
        err_set      = 1'b0;
        frame_done_d = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Everything before the first marker is dropped.
                    if (frame_sync) begin
                        lane_en = slot_to_lane_en(LANE_0);
                        slot_d  = LANE_1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A marker always restarts the frame; arriving
                        // mid-frame abandons the partial frame.
                        lane_en = slot_to_lane_en(LANE_0);
                        slot_d  = LANE_1;
                        err_set = (slot_q != LANE_0);
                    end else if (slot_q == LANE_0) begin
                        // Expected a marker and none came: lose lock.
                        err_set = 1'b1;
                        state_d = HUNT;
                    end else begin
                        lane_en      = slot_to_lane_en(slot_q);
                        slot_d       = slot_q + 2'd1;   // wraps 3 -> 0
                        frame_done_d = (slot_q == LANE_3);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = LANE_0;
                end
            endcase
        end

        // Setting takes priority over clearing in the same cycle.
        sync_err_d = sync_err_q;
        if (err_set) begin
            sync_err_d = 1'b1;
        end else if (err_clr) begin
            sync_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= LANE_0;
            sync_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            sync_err_q   <= sync_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Lane registers
    // -----------------------------------------------------------------------
`ifdef DEMUX_FRAME_BUF_EN
    logic [WIDTH-1:0]   shadow_q     [N_LANES];
    logic [N_LANES-1:0] shadow_valid;
    logic               unused_shadow_valid;

    assign unused_shadow_valid = ^shadow_valid;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
`ifdef DEMUX_FRAME_BUF_EN
            demux_lane_reg #(.WIDTH(WIDTH)) u_shadow (
                .clk   (clk),
                .rst   (rst),
                .load  (lane_en[gi]),
                .d     (d_in),
                .q     (shadow_q[gi]),
                .valid (shadow_valid[gi])
            );

            // On the completing capture the slot-3 word is still on d_in,
            // so that lane bypasses its shadow.
            assign lane_load[gi] = frame_done_d;
            assign lane_din[gi]  = lane_en[gi] ? d_in : shadow_q[gi];
`else
            assign lane_load[gi] = lane_en[gi];
            assign lane_din[gi]  = d_in;
`endif
            demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
                .clk   (clk),
                .rst   (rst),
                .load  (lane_load[gi]),
                .d     (lane_din[gi]),
                .q     (lane_q[gi]),
                .valid (lane_valid[gi])
            );
        end
    endgenerate

    assign out_0      = lane_q[0];
    assign out_1      = lane_q[1];
    assign out_2      = lane_q[2];
    assign out_3      = lane_q[3];
    assign out_valid  = lane_valid;
    assign frame_done = frame_done_q;
    assign locked     = (state_q == LOCKED);
    assign sync_err   = sync_err_q;

endmodule
